// File: rtl/dm_responder.sv
// Data-memory responder for the pipeline core: word-addressed RAM with a
// combinational read port plus a small I/O window (console TX FIFO, status, cycle snapshot).
`timescale 1ns/1ps

module dm_responder #(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             DM_read,
  input  logic             DM_write,
  input  logic [31:0]      DM_addr,
  input  logic [31:0]      DM_in,
  output logic [31:0]      DM_out,
  input  logic [CNT_W-1:0] cycle_count,
  output logic [7:0]       con_data,
  output logic             con_valid,
  input  logic             con_ready,
  output logic             err
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [31:0] CON_TX    = IO_BASE;
  localparam logic [31:0] CON_STAT  = IO_BASE + 32'd4;
  localparam logic [31:0] CYC       = IO_BASE + 32'd8;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // ---------------- address decode ----------------
  logic          access;
  logic          aligned;
  logic          ram_hit;
  logic          tx_hit;
  logic          stat_hit;
  logic          cyc_hit;
  logic          mapped;
  logic [AW-1:0] ram_idx;

  assign access   = DM_read | DM_write;
  assign aligned  = (DM_addr[1:0] == 2'b00);
  assign ram_hit  = (DM_addr < RAM_BYTES);
  assign tx_hit   = (DM_addr == CON_TX);
  assign stat_hit = (DM_addr == CON_STAT);
  assign cyc_hit  = (DM_addr == CYC);
  assign mapped   = ram_hit | tx_hit | stat_hit | cyc_hit;
  assign ram_idx  = DM_addr[AW+1:2];

  logic ram_we;
  logic push;
  logic stat_wr;
  logic err_set;

  assign ram_we  = DM_write & aligned & ram_hit;
  assign push    = DM_write & aligned & tx_hit;
  assign stat_wr = DM_write & aligned & stat_hit;
  // Misaligned accesses of either kind flag an error; unmapped reads are silent.
  assign err_set = (access & ~aligned) | (DM_write & ~mapped);

  // ---------------- RAM ----------------
  logic [31:0] mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= DM_in;
  end

  // ---------------- console TX FIFO ----------------
  // Handshake: a byte transfers on a rising edge where con_valid && con_ready;
  // while con_valid && !con_ready, con_valid and con_data hold their values.
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          overflow;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_ok;
  logic [7:0]    head_next;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign con_valid = ~empty;
  assign pop       = con_valid & con_ready;
  assign push_ok   = push & (~full | pop);

  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  assign rd_ptr_next = pop ? rd_ptr + PW'(1) : rd_ptr;

  // The new head is the byte being pushed when it lands exactly in the head slot.
  always_comb begin
    head_next = 8'h00;
    if (count_next != '0) begin
      if (push_ok && (rd_ptr_next == wr_ptr)) head_next = DM_in[7:0];
      else                                    head_next = fifo_mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= DM_in[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      con_data <= 8'h00;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      con_data <= head_next;
      if (push && !push_ok)            overflow <= 1'b1;
      else if (stat_wr && DM_in[2])    overflow <= 1'b0;
      if (err_set) err <= 1'b1;
    end
  end

  // ---------------- read mux ----------------
  logic [CNT_W+31:0] cyc_ext;
  logic [31:0]       cyc32;
  logic [31:0]       status;
  logic              unused_cyc;

  assign cyc_ext    = {32'd0, cycle_count};
  assign cyc32      = cyc_ext[31:0];
  assign unused_cyc = ^cyc_ext[CNT_W+31:32];
  assign status     = {16'h0000, 8'(count), 5'b00000, overflow, empty, full};

  // Reads of the same word being written see the pre-edge contents.
  always_comb begin
    DM_out = 32'h0000_0000;
    if (DM_read && aligned) begin
      if (ram_hit)       DM_out = mem[ram_idx];
      else if (stat_hit) DM_out = status;
      else if (cyc_hit)  DM_out = cyc32;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed and randomized bench for dm_responder with a queue-based reference model.
`timescale 1ns/1ps

module tb_dm_responder;

  localparam int          RAM_WORDS  = 1024;
  localparam int          FIFO_DEPTH = 8;
  localparam logic [31:0] IO_BASE    = 32'hFFFF_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_in;
  logic [31:0] dm_out;
  logic [31:0] cycle_count;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;
  logic        err;

  always #5 clk = ~clk;

  dm_responder #(
    .RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(32), .IO_BASE(IO_BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .DM_read(dm_read), .DM_write(dm_write), .DM_addr(dm_addr), .DM_in(dm_in),
    .DM_out(dm_out), .cycle_count(cycle_count),
    .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready), .err(err)
  );

  // ---------------- reference model ----------------
  logic [31:0] ref_ram [RAM_WORDS];
  logic [7:0]  ref_q[$];
  logic        ref_ovf;
  logic        ref_err;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (a[1:0] != 2'b00)                 return 32'h0;
    if (a < 32'(RAM_WORDS * 4))          return ref_ram[a >> 2];
    if (a == IO_BASE + 32'd4)
      return {16'h0, 8'(ref_q.size()), 5'b0, ref_ovf, ref_q.size() == 0,
              ref_q.size() == FIFO_DEPTH};
    if (a == IO_BASE + 32'd8)            return cycle_count;
    return 32'h0;
  endfunction

  function automatic logic mapped(input logic [31:0] a);
    return (a < 32'(RAM_WORDS * 4)) || (a == IO_BASE) || (a == IO_BASE + 32'd4) ||
           (a == IO_BASE + 32'd8);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".valid"}, {31'd0, con_valid}, {31'd0, ref_q.size() != 0});
    check({tag, ".data"}, {24'd0, con_data}, {24'd0, (ref_q.size() != 0) ? ref_q[0] : 8'h00});
    check({tag, ".err"}, {31'd0, err}, {31'd0, ref_err});
  endtask

  // ---------------- driver tasks ----------------
  // Apply one clock edge to the model using the inputs currently driven, then advance.
  task automatic step();
    logic [7:0] tmp;
    logic       pop_now;
    pop_now = (ref_q.size() != 0) && con_ready;
    if (pop_now) tmp = ref_q.pop_front();
    if (dm_write && dm_addr == IO_BASE) begin
      if (ref_q.size() < FIFO_DEPTH) ref_q.push_back(dm_in[7:0]);
      else                           ref_ovf = 1'b1;
    end
    if (dm_write && dm_addr == IO_BASE + 32'd4 && dm_in[2]) ref_ovf = 1'b0;
    if ((dm_read || dm_write) && dm_addr[1:0] != 2'b00) ref_err = 1'b1;
    if (dm_write && !mapped(dm_addr)) ref_err = 1'b1;
    if (dm_write && dm_addr[1:0] == 2'b00 && dm_addr < 32'(RAM_WORDS * 4))
      ref_ram[dm_addr >> 2] = dm_in;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input string tag, output logic [31:0] obs);
    dm_read  = rd;
    dm_write = wr;
    dm_addr  = a;
    dm_in    = d;
    #1;
    obs = dm_out;
    check({tag, ".out"}, dm_out, rd ? exp_read(a) : 32'h0);
    step();
    dm_read  = 1'b0;
    dm_write = 1'b0;
    check_regs(tag);
  endtask

  task automatic model_reset();
    ref_q.delete();
    ref_ovf = 1'b0;
    ref_err = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] obs;
    logic [31:0] a;
    int          sel;

    rst = 1'b1; dm_read = 1'b0; dm_write = 1'b0; dm_addr = 32'h0; dm_in = 32'h0;
    cycle_count = 32'h0; con_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_regs("reset");

    // RAM round trip, and DM_out stays 0 with the read strobe low
    access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, "wr10", obs);
    access(1'b1, 1'b0, 32'h10, 32'h0, "rd10", obs);
    check("rd10.const", obs, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 32'h14, 32'h1234_5678, "wr14", obs);
    access(1'b1, 1'b0, 32'h14, 32'h0, "rd14", obs);
    check("rd14.const", obs, 32'h1234_5678);
    access(1'b0, 1'b0, 32'h10, 32'h0, "idle_no_read", obs);

    // Simultaneous read and write to one word: old data visible, new data committed
    access(1'b0, 1'b1, 32'h20, 32'hAAAA_0001, "wr20", obs);
    access(1'b1, 1'b1, 32'h20, 32'hBBBB_0002, "rw20", obs);
    check("rw20.old", obs, 32'hAAAA_0001);
    access(1'b1, 1'b0, 32'h20, 32'h0, "rd20", obs);
    check("rd20.new", obs, 32'hBBBB_0002);

    // Console ordering with a stalled sink
    access(1'b0, 1'b1, IO_BASE, 32'h41, "push41", obs);
    check("lat1.valid", {31'd0, con_valid}, 32'd1);
    access(1'b0, 1'b1, IO_BASE, 32'h42, "push42", obs);
    access(1'b0, 1'b1, IO_BASE, 32'h43, "push43", obs);
    access(1'b0, 1'b0, 32'h0, 32'h0, "hold", obs);
    check("hold.data", {24'd0, con_data}, 32'h41);
    con_ready = 1'b1;
    #1;
    check("drain0", {24'd0, con_data}, 32'h41);
    access(1'b0, 1'b0, 32'h0, 32'h0, "drain1", obs);
    check("drain1.const", {24'd0, con_data}, 32'h42);
    access(1'b0, 1'b0, 32'h0, 32'h0, "drain2", obs);
    check("drain2.const", {24'd0, con_data}, 32'h43);
    access(1'b0, 1'b0, 32'h0, 32'h0, "drain3", obs);
    check("drain3.valid", {31'd0, con_valid}, 32'd0);

    // FIFO full, overflow, clear, push-while-full with a pop
    con_ready = 1'b0;
    for (int i = 0; i < 9; i++) access(1'b0, 1'b1, IO_BASE, 32'h60 + i, "fill", obs);
    access(1'b1, 1'b0, IO_BASE + 32'd4, 32'h0, "stat_full", obs);
    check("stat_full.const", obs, 32'h0000_0805);
    access(1'b0, 1'b1, IO_BASE + 32'd4, 32'h4, "stat_clr", obs);
    access(1'b1, 1'b0, IO_BASE + 32'd4, 32'h0, "stat_clr_rd", obs);
    check("stat_clr.const", obs, 32'h0000_0801);
    con_ready = 1'b1;
    access(1'b0, 1'b1, IO_BASE, 32'h7E, "push_full_pop", obs);
    con_ready = 1'b0;
    access(1'b1, 1'b0, IO_BASE + 32'd4, 32'h0, "stat_after", obs);
    check("stat_after.const", obs, 32'h0000_0801);
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) access(1'b0, 1'b0, 32'h0, 32'h0, "drain_full", obs);

    // Cycle snapshot
    cycle_count = 32'h0000_1234;
    access(1'b1, 1'b0, IO_BASE + 32'd8, 32'h0, "cyc", obs);
    check("cyc.const", obs, 32'h0000_1234);
    access(1'b0, 1'b1, IO_BASE + 32'd8, 32'hFFFF_FFFF, "cyc_wr", obs);
    access(1'b1, 1'b0, IO_BASE, 32'h0, "tx_rd", obs);

    // Errors: misaligned read, then unmapped write after reset
    access(1'b1, 1'b0, 32'h3, 32'h0, "misaligned", obs);
    check("misaligned.const", obs, 32'h0);
    check("misaligned.err", {31'd0, err}, 32'd1);
    pulse_reset();
    check_regs("after_rst");
    access(1'b0, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, "unmapped", obs);
    check("unmapped.err", {31'd0, err}, 32'd1);
    access(1'b1, 1'b0, 32'h10, 32'h0, "keep10", obs);
    access(1'b1, 1'b0, 32'h14, 32'h0, "keep14", obs);
    access(1'b1, 1'b0, 32'h20, 32'h0, "keep20", obs);

    // Asynchronous reset mid-cycle with three bytes queued and err set
    con_ready = 1'b0;
    for (int i = 0; i < 3; i++) access(1'b0, 1'b1, IO_BASE, 32'h31 + i, "pre_rst", obs);
    #2;
    rst = 1'b1;
    dm_read = 1'b1;
    dm_addr = IO_BASE + 32'd4;
    #1;
    check("arst.valid", {31'd0, con_valid}, 32'd0);
    check("arst.stat", dm_out, 32'h0000_0002);
    check("arst.err", {31'd0, err}, 32'd0);
    dm_read = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_regs("arst_release");

    // Randomized traffic over 16 pre-initialised RAM words and the I/O window
    for (int i = 0; i < 16; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, "init", obs);
    for (int i = 0; i < 400; i++) begin
      sel         = $urandom_range(0, 9);
      con_ready   = 1'($urandom_range(0, 1));
      cycle_count = $urandom;
      a           = 32'($urandom_range(0, 15) * 4);
      case (sel)
        0, 1, 2: access(1'b0, 1'b1, a, $urandom, "r_wr", obs);
        3, 4:    access(1'b1, 1'b0, a, 32'h0, "r_rd", obs);
        5, 6:    access(1'b0, 1'b1, IO_BASE, $urandom, "r_push", obs);
        7:       access(1'b1, $urandom_range(0, 3) == 0, IO_BASE + 32'd4, 32'h4, "r_stat", obs);
        8:       access(1'b1, 1'b0, IO_BASE + 32'd8, 32'h0, "r_cyc", obs);
        default: access(1'b0, 1'b0, $urandom, 32'h0, "r_idle", obs);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
